// File: rtl/rob_commit.sv
// rob_commit: in-order retirement buffer for the out-of-order core.
// Allocates tags at issue, answers operand-readiness queries, captures CDB
// results and retires the head entry, flushing everything on a committed
// branch mispredict.
// Optional feature macro: ROB_CDB_BYPASS_EN forwards a same-cycle CDB result
// to the rs1/rs2 queries; when undefined, queries see stored state only.

module rob_commit #(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,

    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_is_store,
    input  logic                     issue_is_branch,
    input  logic                     issue_ready,
    input  logic [31:0]              issue_val,
    output logic                     rob_full,
    output logic [4:0]               new_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,

    input  logic                     cdb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
    input  logic [31:0]              cdb_val,
    input  logic                     cdb_mispredict,
    input  logic [31:0]              cdb_target,

    input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
    input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
    output logic                     rs1_ready,
    output logic                     rs2_ready,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val,

    output logic [4:0]               write_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
    output logic [31:0]              write_val,
    output logic                     store_commit,
    output logic                     clear_flag,
    output logic [31:0]              redirect_pc
);

    localparam int DEPTH = 1 << ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0] FULL_COUNT = (ROB_WIDTH_BIT + 1)'(DEPTH);

    typedef logic [ROB_WIDTH_BIT-1:0] tag_t;
    typedef logic [ROB_WIDTH_BIT:0]   cnt_t;

    // Control state (reset)
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    tag_t             head;
    tag_t             tail;
    cnt_t             count;

    // Payload storage (not reset; only meaningful while busy/ready)
    logic [4:0]  rd_mem      [DEPTH];
    logic        store_mem   [DEPTH];
    logic        branch_mem  [DEPTH];
    logic        mispred_mem [DEPTH];
    logic [31:0] val_mem     [DEPTH];
    logic [31:0] target_mem  [DEPTH];

    logic issue_fire;
    logic cdb_fire;
    logic commit_fire;
    logic flush_fire;

    // Handshake decode: which of issue / writeback / commit / flush happen this edge
    always_comb begin
        rob_full    = (count == FULL_COUNT);
        commit_fire = rdy_in && (count != '0) && ready[head];
        flush_fire  = commit_fire && mispred_mem[head];
        // A flushing commit discards the tail, so an issue in that cycle is dropped.
        issue_fire  = rdy_in && issue_valid && !rob_full && !clear_flag && !flush_fire;
        cdb_fire    = rdy_in && cdb_valid && !clear_flag && busy[cdb_rob_id];
        new_reg_id  = issue_fire ? issue_rd : 5'd0;
        new_ROB_id  = tail;
    end

    // Operand queries, optionally forwarding the CDB value in flight this cycle
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rs1_ready = ready[rs1_id];
        rs1_val   = val_mem[rs1_id];
        rs2_ready = ready[rs2_id];
        rs2_val   = val_mem[rs2_id];
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (cdb_rob_id == rs1_id)) begin
            rs1_ready = 1'b1;
            rs1_val   = cdb_val;
        end
        if (cdb_valid && (cdb_rob_id == rs2_id)) begin
            rs2_ready = 1'b1;
            rs2_val   = cdb_val;
        end
`endif
    end

    // Pointer, occupancy and busy/ready bookkeeping
    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
        if (!rst_in) begin
            busy  <= '0;
            ready <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (cdb_fire) begin
                ready[cdb_rob_id] <= 1'b1;
            end
            if (issue_fire) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= issue_ready;
                tail        <= tail + tag_t'(1);
            end
            if (commit_fire) begin
                busy[head] <= 1'b0;
                head       <= head + tag_t'(1);
            end
            count <= count + cnt_t'(issue_fire) - cnt_t'(commit_fire);
            if (flush_fire) begin
                busy  <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end
        end
    end

    // Entry payload written at issue and at writeback
    always_ff @(posedge clk_in) begin
        // NOTE: payload arrays carry no reset; busy/ready gate every use of them.
        if (issue_fire) begin
            rd_mem[tail]      <= issue_rd;
            store_mem[tail]   <= issue_is_store;
            branch_mem[tail]  <= issue_is_branch;
            mispred_mem[tail] <= 1'b0;
            val_mem[tail]     <= issue_val;
        end
        if (cdb_fire) begin
            val_mem[cdb_rob_id]     <= cdb_val;
            // Only an entry issued as a branch may request a flush.
            mispred_mem[cdb_rob_id] <= cdb_mispredict && branch_mem[cdb_rob_id];
            target_mem[cdb_rob_id]  <= cdb_target;
        end
    end

    // Registered commit port: one-cycle pulses, frozen while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            write_reg_id <= '0;
            write_ROB_id <= '0;
            write_val    <= '0;
            store_commit <= 1'b0;
            clear_flag   <= 1'b0;
            redirect_pc  <= '0;
        end else if (commit_fire) begin
            write_reg_id <= rd_mem[head];
            write_ROB_id <= head;
            write_val    <= val_mem[head];
            store_commit <= store_mem[head];
            clear_flag   <= mispred_mem[head];
            if (mispred_mem[head]) begin
                redirect_pc <= target_mem[head];
            end
        end else if (rdy_in) begin
            write_reg_id <= '0;
            store_commit <= 1'b0;
            clear_flag   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios followed by random
// traffic, all compared against an in-order queue model of the buffer.
module tb_rob_commit;

    localparam int W     = 3;
    localparam int DEPTH = 1 << W;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           rdy_in;
    logic           issue_valid;
    logic [4:0]     issue_rd;
    logic           issue_is_store;
    logic           issue_is_branch;
    logic           issue_ready;
    logic [31:0]    issue_val;
    logic           rob_full;
    logic [4:0]     new_reg_id;
    logic [W-1:0]   new_ROB_id;
    logic           cdb_valid;
    logic [W-1:0]   cdb_rob_id;
    logic [31:0]    cdb_val;
    logic           cdb_mispredict;
    logic [31:0]    cdb_target;
    logic [W-1:0]   rs1_id;
    logic [W-1:0]   rs2_id;
    logic           rs1_ready;
    logic           rs2_ready;
    logic [31:0]    rs1_val;
    logic [31:0]    rs2_val;
    logic [4:0]     write_reg_id;
    logic [W-1:0]   write_ROB_id;
    logic [31:0]    write_val;
    logic           store_commit;
    logic           clear_flag;
    logic [31:0]    redirect_pc;

    rob_commit #(.ROB_WIDTH_BIT(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_is_store(issue_is_store), .issue_is_branch(issue_is_branch),
        .issue_ready(issue_ready), .issue_val(issue_val),
        .rob_full(rob_full), .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id),
        .write_val(write_val), .store_commit(store_commit),
        .clear_flag(clear_flag), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned q[$];          // in-flight tags, oldest first
    int          m_tail;
    bit          m_ready [DEPTH];
    logic [31:0] m_val   [DEPTH];
    logic [4:0]  m_rd    [DEPTH];
    bit          m_st    [DEPTH];
    bit          m_br    [DEPTH];
    bit          m_mis   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    logic [4:0]  e_wreg;
    logic [31:0] e_wtag;
    logic [31:0] e_wval;
    bit          e_st;
    bit          e_clr;
    logic [31:0] e_pc;

    function automatic bit in_flight(input int unsigned t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        for (int i = 0; i < DEPTH; i++) m_ready[i] = 1'b0;
        e_wreg = '0; e_wtag = '0; e_wval = '0; e_st = 1'b0; e_clr = 1'b0; e_pc = '0;
    endtask

    task automatic query_check(input string tag, input int id, input logic obs_r,
                               input logic [31:0] obs_v);
        bit          exp_r;
        logic [31:0] exp_v;
        exp_r = m_ready[id];
        exp_v = m_val[id];
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (int'(cdb_rob_id) == id)) begin
            exp_r = 1'b1;
            exp_v = cdb_val;
        end
`endif
        check({tag, "_ready"}, obs_r, exp_r);
        if (exp_r) check({tag, "_val"}, obs_v, exp_v);
    endtask

    // One clock cycle: inputs already driven after the falling edge.
    task automatic step();
        bit full, commit, flush, accept, cdb_ok;
        int h, t, c;
        #1;
        full   = (q.size() == DEPTH);
        commit = rdy_in && (q.size() > 0) && m_ready[q[0]];
        flush  = commit && m_mis[q[0]];
        accept = rdy_in && issue_valid && !full && !e_clr && !flush;
        c      = int'(cdb_rob_id);
        cdb_ok = rdy_in && cdb_valid && !e_clr && in_flight(c);

        check("rob_full", rob_full, full);
        check("new_reg_id", new_reg_id, accept ? issue_rd : 5'd0);
        check("new_ROB_id", new_ROB_id, m_tail);
        query_check("rs1", int'(rs1_id), rs1_ready, rs1_val);
        query_check("rs2", int'(rs2_id), rs2_ready, rs2_val);

        if (commit) begin
            h      = q.pop_front();
            e_wreg = m_rd[h];
            e_wtag = h;
            e_wval = m_val[h];
            e_st   = m_st[h];
            e_clr  = m_mis[h];
            if (m_mis[h]) e_pc = m_tgt[h];
        end else if (rdy_in) begin
            e_wreg = '0;
            e_st   = 1'b0;
            e_clr  = 1'b0;
        end
        if (cdb_ok) begin
            m_ready[c] = 1'b1;
            m_val[c]   = cdb_val;
            m_mis[c]   = cdb_mispredict && m_br[c];
            m_tgt[c]   = cdb_target;
        end
        if (accept) begin
            t          = m_tail;
            m_ready[t] = issue_ready;
            m_val[t]   = issue_val;
            m_rd[t]    = issue_rd;
            m_st[t]    = issue_is_store;
            m_br[t]    = issue_is_branch;
            m_mis[t]   = 1'b0;
            q.push_back(t);
            m_tail     = (m_tail + 1) % DEPTH;
        end
        if (flush) begin
            q.delete();
            m_tail = 0;
        end

        @(posedge clk_in);
        #1;
        check("write_reg_id", write_reg_id, e_wreg);
        check("write_ROB_id", write_ROB_id, e_wtag);
        check("write_val", write_val, e_wval);
        check("store_commit", store_commit, e_st);
        check("clear_flag", clear_flag, e_clr);
        check("redirect_pc", redirect_pc, e_pc);
        @(negedge clk_in);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rdy_in = 1'b1;
        issue_valid = 1'b0; issue_rd = '0; issue_is_store = 1'b0; issue_is_branch = 1'b0;
        issue_ready = 1'b0; issue_val = '0;
        cdb_valid = 1'b0; cdb_rob_id = '0; cdb_val = '0; cdb_mispredict = 1'b0; cdb_target = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input bit rdy, input logic [31:0] v,
                         input bit st, input bit br);
        idle();
        issue_valid = 1'b1; issue_rd = rd; issue_ready = rdy; issue_val = v;
        issue_is_store = st; issue_is_branch = br;
        step();
    endtask

    task automatic cdb(input int tag, input logic [31:0] v, input bit mis, input logic [31:0] tgt);
        idle();
        cdb_valid = 1'b1; cdb_rob_id = W'(tag); cdb_val = v;
        cdb_mispredict = mis; cdb_target = tgt;
        step();
    endtask

    // Asserted right after a falling edge, released at the next falling edge.
    task automatic do_reset();
        idle();
        rst_in = 1'b0;
        #1;
        model_reset();
        check("rst_rob_full", rob_full, 1'b0);
        check("rst_write_reg_id", write_reg_id, 5'd0);
        check("rst_clear_flag", clear_flag, 1'b0);
        check("rst_store_commit", store_commit, 1'b0);
        check("rst_write_val", write_val, 32'd0);
        check("rst_new_ROB_id", new_ROB_id, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        rs1_id = '0;
        rs2_id = '0;
        idle();
        rst_in = 1'b1;
        @(negedge clk_in);
        do_reset();

        // Reset with five entries in flight; first tag afterwards is 0.
        for (int i = 0; i < 5; i++) issue(5'(i + 1), 1'b0, 32'(i), 1'b0, 1'b0);
        do_reset();
        issue(5'd9, 1'b0, 32'h99, 1'b0, 1'b0);
        idle(); step();

        // Out-of-order writeback, in-order retirement.
        do_reset();
        issue(5'd5, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(5'd6, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(5'd7, 1'b0, 32'h0, 1'b0, 1'b0);
        cdb(2, 32'h30, 1'b0, 32'h0);
        cdb(0, 32'h10, 1'b0, 32'h0);
        cdb(1, 32'h20, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin idle(); step(); end

        // Fill to eight, wrap: ninth issue held until a slot frees, then tag 0.
        do_reset();
        for (int i = 0; i < DEPTH; i++) issue(5'(i + 10), 1'b0, 32'(i), 1'b0, 1'b0);
        idle(); cdb_valid = 1'b1; cdb_rob_id = '0; cdb_val = 32'h77;
        issue_valid = 1'b1; issue_rd = 5'd20; issue_ready = 1'b1; issue_val = 32'h55;
        step();
        cdb_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        for (int i = 1; i < DEPTH; i++) cdb(i, 32'(i * 3), 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin idle(); step(); end

        // Committed mispredict on tag 2 with tags 3..5 busy.
        do_reset();
        for (int i = 0; i < 6; i++)
            issue((i == 2) ? 5'd1 : 5'(i + 8), 1'b0, 32'h0, 1'b0, i == 2);
        cdb(2, 32'h44, 1'b1, 32'h1000);
        cdb(0, 32'h40, 1'b0, 32'h0);
        idle(); cdb_valid = 1'b1; cdb_rob_id = 3'd1; cdb_val = 32'h41;
        issue_valid = 1'b1; issue_rd = 5'd3; step();
        idle(); issue_valid = 1'b1; issue_rd = 5'd4; step();
        idle(); issue_valid = 1'b1; issue_rd = 5'd12; issue_ready = 1'b1; cdb_valid = 1'b1;
        cdb_rob_id = 3'd0; step();
        for (int i = 0; i < 2; i++) begin idle(); step(); end

        // Same-cycle query of a tag being written back.
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'(i + 1), 1'b0, 32'h0, 1'b0, 1'b0);
        rs1_id = 3'd3; rs2_id = 3'd2;
        cdb(3, 32'hABCD, 1'b0, 32'h0);
        idle(); step();

        // Store retiring around a three-cycle rdy_in stall.
        do_reset();
        issue(5'd0, 1'b1, 32'h5, 1'b1, 1'b0);
        idle(); step();
        for (int i = 0; i < 3; i++) begin idle(); rdy_in = 1'b0; step(); end
        for (int i = 0; i < 2; i++) begin idle(); step(); end
        issue(5'd0, 1'b1, 32'h6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin idle(); rdy_in = 1'b0; step(); end
        for (int i = 0; i < 2; i++) begin idle(); step(); end

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            idle();
            rdy_in          = ($urandom_range(0, 9) != 0);
            issue_valid     = ($urandom_range(0, 2) != 0);
            issue_rd        = 5'($urandom);
            issue_is_store  = ($urandom_range(0, 5) == 0);
            issue_is_branch = ($urandom_range(0, 3) == 0);
            issue_ready     = ($urandom_range(0, 2) == 0);
            issue_val       = $urandom;
            cdb_valid       = ($urandom_range(0, 1) == 0);
            if ((q.size() > 0) && ($urandom_range(0, 3) != 0))
                cdb_rob_id = W'(q[$urandom_range(0, q.size() - 1)]);
            else
                cdb_rob_id = W'($urandom);
            cdb_val         = $urandom;
            cdb_mispredict  = ($urandom_range(0, 5) == 0);
            cdb_target      = $urandom;
            rs1_id          = W'($urandom);
            rs2_id          = W'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
